// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_mux_ser serializer.
// The PARITY state is only reachable when the design is built with PARITY_EN.
package piso_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] SEL_LO = 3'd0;
    localparam logic [SEL_W-1:0] SEL_HI = 3'd7;

    // First and last mux select of a frame for the chosen bit order.
    function automatic logic [SEL_W-1:0] sel_start(input bit lsb_first);
        return lsb_first ? SEL_LO : SEL_HI;
    endfunction

    function automatic logic [SEL_W-1:0] sel_end(input bit lsb_first);
        return lsb_first ? SEL_HI : SEL_LO;
    endfunction

endpackage

// File: rtl/mux_81.sv
// 8:1 single-bit multiplexer: y = i[s].
module mux_81
    import piso_pkg::*;
(
    input  logic [DATA_W-1:0] i,
    input  logic [SEL_W-1:0]  s,
    output logic              y
);

    assign y = i[s];

endmodule

// File: rtl/piso_mux_ser.sv
// Parallel-in serial-out frame serializer driving an 8:1 mux from a select counter.
// Build option: define PARITY_EN to append an even-parity bit as a ninth frame bit.
module piso_mux_ser
    import piso_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              frame_start,
    output logic              frame_end,
    output logic [SEL_W-1:0]  sel,
    output logic              busy
);

    localparam logic [SEL_W-1:0] SEL_START = sel_start(LSB_FIRST);
    localparam logic [SEL_W-1:0] SEL_END   = sel_end(LSB_FIRST);

    state_t              r_state;
    logic [DATA_W-1:0]   r_hold;
    logic [SEL_W-1:0]    r_sel;

    state_t              w_next_state;
    logic [DATA_W-1:0]   w_next_hold;
    logic [SEL_W-1:0]    w_next_sel;
    logic                w_ready_raw;
    logic                w_ser_valid;
    logic                w_ser_bit;
    logic                w_frame_start;
    logic                w_frame_end;
    logic                w_mux_bit;

    mux_81 u_mux (
        .i (r_hold),
        .s (r_sel),
        .y (w_mux_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_sel   <= '0;
        end else begin
            r_state <= w_next_state;
            r_hold  <= w_next_hold;
            r_sel   <= w_next_sel;
        end
    end

    // Handshake: a word is taken on a rising edge where din_valid and din_ready are both high.
    always_comb begin
        w_next_state  = r_state;
        w_next_hold   = r_hold;
        w_next_sel    = r_sel;
        w_ready_raw   = 1'b0;
        w_ser_valid   = 1'b0;
        w_ser_bit     = 1'b0;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready_raw = 1'b1;
                if (din_valid) begin
                    w_next_hold  = din;
                    w_next_sel   = SEL_START;
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                w_ser_valid   = 1'b1;
                w_ser_bit     = w_mux_bit;
                w_frame_start = (r_sel == SEL_START);
                w_next_sel    = LSB_FIRST ? (r_sel + 3'd1) : (r_sel - 3'd1);
                if (r_sel == SEL_END) begin
`ifdef PARITY_EN
                    w_next_state = PARITY;
`else
                    w_ready_raw = 1'b1;
                    w_frame_end = 1'b1;
                    if (din_valid) begin
                        w_next_hold  = din;
                        w_next_sel   = SEL_START;
                        w_next_state = SHIFT;
                    end else begin
                        w_next_state = IDLE;
                    end
`endif
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                w_ser_valid = 1'b1;
                w_ser_bit   = ^r_hold;
                w_frame_end = 1'b1;
                w_ready_raw = 1'b1;
                if (din_valid) begin
                    w_next_hold  = din;
                    w_next_sel   = SEL_START;
                    w_next_state = SHIFT;
                end else begin
                    w_next_state = IDLE;
                end
            end
`endif
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Ready is masked while in reset so no handshake is seen as accepted.
    assign din_ready   = rst_n & w_ready_raw;
    assign ser_out     = w_ser_bit;
    assign ser_valid   = w_ser_valid;
    assign frame_start = w_frame_start;
    assign frame_end   = w_frame_end;
    assign sel         = r_sel;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_piso_mux_ser.sv
// Directed bench for piso_mux_ser: one LSB-first and one MSB-first instance, each with a
// scoreboard queue of expected frame bits filled when a word is accepted.
module tb_piso_mux_ser;

    localparam int W = 7;  // {check_sel, sel[2:0], frame_start, frame_end, ser_out}
`ifdef PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din_a = '0, din_b = '0;
    logic       din_valid_a = 1'b0, din_valid_b = 1'b0;
    logic       din_ready_a, din_ready_b;
    logic       ser_out_a, ser_out_b, ser_valid_a, ser_valid_b;
    logic       frame_start_a, frame_start_b, frame_end_a, frame_end_b;
    logic [2:0] sel_a, sel_b;
    logic       busy_a, busy_b;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic acc_a = 1'b0, acc_b = 1'b0;
    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];
    logic [W-1:0] e_a, e_b;
    logic ev_a, ev_b, rdy_a, rdy_b;

    always #5 clk = ~clk;

    piso_mux_ser #(.LSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din_a), .din_valid(din_valid_a),
        .din_ready(din_ready_a), .ser_out(ser_out_a), .ser_valid(ser_valid_a),
        .frame_start(frame_start_a), .frame_end(frame_end_a), .sel(sel_a), .busy(busy_a)
    );

    piso_mux_ser #(.LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(din_valid_b),
        .din_ready(din_ready_b), .ser_out(ser_out_b), .ser_valid(ser_valid_b),
        .frame_start(frame_start_b), .frame_end(frame_end_b), .sel(sel_b), .busy(busy_b)
    );

    function automatic logic [W-1:0] mk_entry(input logic [7:0] w, input int b, input bit lsb);
        int idx;
        logic [2:0] s;
        if (b >= 8) return {1'b0, 3'd0, 1'b0, 1'b1, ^w};
        idx = lsb ? b : 7 - b;
        s = idx[2:0];
        return {1'b1, s, (b == 0), (b == NB - 1), w[idx]};
    endfunction

    // Scoreboard for the LSB-first instance.
    always @(negedge clk) begin
        if (mon_en) begin
            ev_a = (exp_a.size() > 0);
            checks++;
            assert (ser_valid_a === ev_a) else begin errors++; $error("FAIL a_ser_valid got %b exp %b", ser_valid_a, ev_a); end
            checks++;
            assert (busy_a === ev_a) else begin errors++; $error("FAIL a_busy got %b exp %b", busy_a, ev_a); end
            if (ev_a) begin
                e_a = exp_a.pop_front();
                checks++;
                assert ({frame_start_a, frame_end_a, ser_out_a} === e_a[2:0]) else begin
                    errors++; $error("FAIL a_bit got %b exp %b", {frame_start_a, frame_end_a, ser_out_a}, e_a[2:0]);
                end
                if (e_a[6]) begin
                    checks++;
                    assert (sel_a === e_a[5:3]) else begin errors++; $error("FAIL a_sel got %0d exp %0d", sel_a, e_a[5:3]); end
                end
            end else begin
                checks++;
                assert ({frame_start_a, frame_end_a} === 2'b00) else begin
                    errors++; $error("FAIL a_idle_strobes got %b exp 00", {frame_start_a, frame_end_a});
                end
            end
            if (!rst_n) exp_a.delete();
            rdy_a = rst_n && (exp_a.size() == 0);
            checks++;
            assert (din_ready_a === rdy_a) else begin errors++; $error("FAIL a_din_ready got %b exp %b", din_ready_a, rdy_a); end
            if (rdy_a && din_valid_a) begin
                for (int b = 0; b < NB; b++) exp_a.push_back(mk_entry(din_a, b, 1'b1));
                acc_a = 1'b1;
            end
        end
    end

    // Scoreboard for the MSB-first instance.
    always @(negedge clk) begin
        if (mon_en) begin
            ev_b = (exp_b.size() > 0);
            checks++;
            assert (ser_valid_b === ev_b) else begin errors++; $error("FAIL b_ser_valid got %b exp %b", ser_valid_b, ev_b); end
            checks++;
            assert (busy_b === ev_b) else begin errors++; $error("FAIL b_busy got %b exp %b", busy_b, ev_b); end
            if (ev_b) begin
                e_b = exp_b.pop_front();
                checks++;
                assert ({frame_start_b, frame_end_b, ser_out_b} === e_b[2:0]) else begin
                    errors++; $error("FAIL b_bit got %b exp %b", {frame_start_b, frame_end_b, ser_out_b}, e_b[2:0]);
                end
                if (e_b[6]) begin
                    checks++;
                    assert (sel_b === e_b[5:3]) else begin errors++; $error("FAIL b_sel got %0d exp %0d", sel_b, e_b[5:3]); end
                end
            end
            if (!rst_n) exp_b.delete();
            rdy_b = rst_n && (exp_b.size() == 0);
            checks++;
            assert (din_ready_b === rdy_b) else begin errors++; $error("FAIL b_din_ready got %b exp %b", din_ready_b, rdy_b); end
            if (rdy_b && din_valid_b) begin
                for (int b = 0; b < NB; b++) exp_b.push_back(mk_entry(din_b, b, 1'b0));
                acc_b = 1'b1;
            end
        end
    end

    task automatic send(input bit use_b, input logic [7:0] w, input bit keep);
        logic got;
        got = 1'b0;
        @(posedge clk); #1;
        if (use_b) begin din_b = w; din_valid_b = 1'b1; acc_b = 1'b0; end
        else begin din_a = w; din_valid_a = 1'b1; acc_a = 1'b0; end
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk); #1;
            got = use_b ? acc_b : acc_a;
        end
        checks++;
        assert (got === 1'b1) else begin errors++; $error("FAIL accept_timeout got %b exp 1", got); end
        @(posedge clk); #1;
        if (use_b) begin acc_b = 1'b0; if (!keep) din_valid_b = 1'b0; end
        else begin acc_a = 1'b0; if (!keep) din_valid_a = 1'b0; end
    endtask

    task automatic wait_idle(input bit use_b);
        logic done;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk); #1;
            done = use_b ? (exp_b.size() == 0) : (exp_a.size() == 0);
        end
        checks++;
        assert (done === 1'b1) else begin errors++; $error("FAIL idle_timeout got %b exp 1", done); end
        @(posedge clk); #1;
        checks++;
        assert ((use_b ? busy_b : busy_a) === 1'b0) else begin errors++; $error("FAIL busy_after_frame got 1 exp 0"); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        checks++;
        assert ({din_ready_a, ser_valid_a, busy_a, ser_out_a, frame_start_a, frame_end_a} === 6'b0) else begin
            errors++; $error("FAIL reset_outputs got %b exp 000000",
                {din_ready_a, ser_valid_a, busy_a, ser_out_a, frame_start_a, frame_end_a});
        end
        checks++;
        assert (sel_a === 3'd0) else begin errors++; $error("FAIL reset_sel_a got %0d exp 0", sel_a); end
        checks++;
        assert (sel_b === 3'd0) else begin errors++; $error("FAIL reset_sel_b got %0d exp 0", sel_b); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        assert (din_ready_a === 1'b1) else begin errors++; $error("FAIL ready_after_release got %b exp 1", din_ready_a); end

        // Single LSB-first word, then MSB-first word
        send(1'b0, 8'hA5, 1'b0);
        wait_idle(1'b0);
        send(1'b1, 8'h81, 1'b0);
        wait_idle(1'b1);
        send(1'b1, 8'h5A, 1'b0);
        wait_idle(1'b1);

        // Back-to-back frames with din_valid held high
        send(1'b0, 8'h0F, 1'b1);
        send(1'b0, 8'hF0, 1'b0);
        wait_idle(1'b0);

        // Source wiggles din/din_valid mid-frame; the held word must not change
        send(1'b0, 8'h3C, 1'b0);
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            din_valid_a = 1'($urandom_range(0, 1));
            din_a = 8'($urandom_range(0, 255));
        end
        @(posedge clk); #1;
        din_valid_a = 1'b0;
        wait_idle(1'b0);

        // Parity-sensitive words (ninth bit present only in the parity build)
        send(1'b0, 8'h07, 1'b0);
        wait_idle(1'b0);
        send(1'b0, 8'h03, 1'b0);
        wait_idle(1'b0);

        // Reset during the fourth bit of a frame
        send(1'b0, 8'hFF, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        din_a = 8'h55;
        din_valid_a = 1'b1;
        @(posedge clk); #1;
        checks++;
        assert ({ser_valid_a, frame_end_a, din_ready_a, busy_a} === 4'b0000) else begin
            errors++; $error("FAIL reset_abort got %b exp 0000", {ser_valid_a, frame_end_a, din_ready_a, busy_a});
        end
        din_valid_a = 1'b0;
        rst_n = 1'b1;
        send(1'b0, 8'h00, 1'b0);
        wait_idle(1'b0);

        // A few random words on both instances
        for (int n = 0; n < 4; n++) begin
            send(1'b0, 8'($urandom_range(0, 255)), 1'b0);
            wait_idle(1'b0);
            send(1'b1, 8'($urandom_range(0, 255)), 1'b0);
            wait_idle(1'b1);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_mux_ser.md
# piso_mux_ser

Parallel-in, serial-out frame serializer that accepts an 8-bit word over a valid/ready handshake and emits it one bit per clock. A 3-bit select counter walks an 8:1 bit-select mux across the held word, so this block is the sequencing stage wrapped around the team's 8:1 mux. Its output feeds downstream serial consumers together with frame-start and frame-end strobes.

## Interface
- LSB_FIRST, default 1: 1 sends bit 0 first (sel counts 0→7); 0 sends bit 7 first (sel counts 7→0).
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  reset, synchronous and active-low.
- din  in  8  parallel word.
- din_valid  in  1  din is valid.
- din_ready  out  1  block can accept din this cycle.
- ser_out  out  1  current serial bit.
- ser_valid  out  1  ser_out carries a frame bit.
- frame_start  out  1  high on the first bit of a frame.
- frame_end  out  1  high on the last bit of a frame.
- sel  out  3  current mux select, exposed for debug and coverage.
- busy  out  1  frame in progress (state != IDLE).

## Operation
- States: IDLE, SHIFT, plus PARITY when PARITY_EN is defined.
- IDLE:
  - din_ready=1.
  - On din_valid&&din_ready, capture din into hold, load sel with the start index (0 if LSB_FIRST, else 7), then go to SHIFT.
- SHIFT:
  - ser_valid=1 and ser_out=hold[sel], selected through the 8:1 mux.
  - sel steps by +1 (LSB_FIRST) or -1 each cycle.
  - frame_start=1 when sel equals the start index.
  - The last-bit cycle is the one where sel equals the end index (7 if LSB_FIRST, else 0).
- At the last-bit cycle, without PARITY_EN:
  - frame_end=1 and din_ready=1.
  - If din_valid, capture the new word, reload sel and stay in SHIFT (back-to-back frames with no gap).
  - Otherwise go to IDLE.
- At the last-bit cycle, with PARITY_EN: go to PARITY. din_ready stays 0.
- din_ready=0 in every other SHIFT cycle. din_valid is ignored there and the word must be held by the source.
- hold changes only on an accepted handshake.
- sel arithmetic is 3-bit modulo. The wrap from the end index is never visible because sel is reloaded on every frame.

## Timing
- While rst_n is low at a clock edge:
  - Registers go to state=IDLE, hold=0, sel=0.
  - Outputs: ser_out=0, ser_valid=0, frame_start=0, frame_end=0, busy=0.
  - din_ready=0 (gated by rst_n). It reads 1 on the first cycle after release.
- Latency: a word accepted at edge k produces bit 0 of the frame in cycle k+1, valid after edge k.
- Frame length is 8 cycles, or 9 with PARITY_EN.
- Sustained throughput is one word per 8 cycles, or one per 9 with PARITY_EN.
- Reset mid-frame aborts the frame: no frame_end and the word is dropped. The block is in IDLE the cycle after.
- A handshake presented while rst_n is low is not accepted.
- din_valid may drop without an accept; no word is lost or duplicated.
- An 8-cycle frame has exactly one frame_start and one frame_end, in different cycles.

## Configuration
- PARITY_EN defined:
  - After the 8 data bits, the PARITY state drives ser_out=^hold (even parity over the held word), ser_valid=1 and frame_end=1, with din_ready=1.
  - An accept in this cycle starts the next frame back-to-back; otherwise the block goes to IDLE.
  - frame_end is not asserted on data bit 8.
- PARITY_EN undefined: the PARITY state and its logic are absent and frames are 8 bits.

## Structure
- Package piso_pkg holds:
  - The state enum (IDLE, SHIFT, PARITY).
  - DATA_W=8 and SEL_W=3.
  - The sel start and end constants, derived from LSB_FIRST.
- Sub-module: the existing mux_81 (i=hold, s=sel, y=ser_out path), instantiated once.
- Everything else lives in one always block for registers and one for next-state logic.

## Test plan
- Reset, then a single word din=8'hA5 with LSB_FIRST=1 → ser_out 1,0,1,0,0,1,0,1 over cycles k+1..k+8, frame_start at k+1, frame_end at k+8, then busy=0.
- LSB_FIRST=0, din=8'h81 → sel sequence 7..0 and ser_out 1,0,0,0,0,0,0,1.
- din_valid held high with words 8'h0F then 8'hF0 → 16 contiguous ser_valid cycles. din_ready is high only in IDLE and in the last-bit cycles.
- rst_n pulled low at bit 4 of 8'hFF → the next cycle has ser_valid=0, no frame_end and din_ready=0. After release the block accepts 8'h00 cleanly.
- PARITY_EN, din=8'h07 → 9 bits with a 9th bit of 1 and frame_end on bit 9. With din=8'h03 the 9th bit is 0.
- din_valid toggled during SHIFT with changing din → hold is unchanged and the emitted bits match the originally accepted word.
